// File: rtl/button_mmio.sv
// button_mmio: push-button peripheral on the data-memory port.
// The raw button is synchronised and debounced. The peripheral counts presses,
// keeps a sticky pressed flag, and exposes one status word at BTN_ADDR. Loads
// from that address return the status word in place of RAM data, and stores to
// it never reach RAM.
module button_mmio #(
   parameter int BTN_ADDR        = 24,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        btn_raw,
   input  logic [31:0] address_dmem,
   input  logic        wren,
   input  logic [31:0] data,
   input  logic [31:0] ram_q,
   output logic        ram_wren,
   output logic [31:0] q_dmem,
   output logic        btn_level,
   output logic        btn_pressed,
   output logic [7:0]  press_count
);

   typedef enum logic [1:0] {S_LOW, S_RISE, S_HIGH, S_FALL} state_t;

   localparam logic [11:0]      ADDR_LO  = 12'(BTN_ADDR);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s1_q, s2_q;
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             level_q;
   logic             pressed_q, pressed_d;
   logic [7:0]       count_q, count_d;
   logic             hit_q;
   logic [31:0]      snap_q, status_d;

   logic             hit, rd_acc, wr_acc, press_evt;
   logic             unused_bits;

   // Only address bits [11:0] take part in decoding. Only data bits [1:0] are control bits.
   assign unused_bits = ^{address_dmem[31:12], data[31:2]};

   assign hit       = (address_dmem[11:0] == ADDR_LO);
   assign rd_acc    = hit & ~wren;
   assign wr_acc    = hit & wren;
   assign press_evt = (state_q == S_RISE) && s2_q && (cnt_q == CNT_LAST);
   assign status_d  = {16'b0, count_q, 6'b0, pressed_q, level_q};

   assign ram_wren    = wren & ~hit;
   assign q_dmem      = hit_q ? snap_q : ram_q;
   assign btn_level   = level_q;
   assign btn_pressed = pressed_q;
   assign press_count = count_q;

   // Two-flop synchroniser for the asynchronous button input.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= btn_raw;
         s2_q <= s1_q;
      end
   end

   // Debounce FSM: a new level must hold DEBOUNCE_CYCLES clocks; level_q follows the state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_LOW;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         case (state_q)
            S_LOW: begin
               if (s2_q) begin
                  state_q <= S_RISE;
                  cnt_q   <= CNT_ONE;
               end
            end
            S_RISE: begin
               if (!s2_q) begin
                  state_q <= S_LOW;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= S_HIGH;
                  cnt_q   <= '0;
                  level_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            S_HIGH: begin
               if (!s2_q) begin
                  state_q <= S_FALL;
                  cnt_q   <= CNT_ONE;
               end
            end
            S_FALL: begin
               if (s2_q) begin
                  state_q <= S_HIGH;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= S_LOW;
                  cnt_q   <= '0;
                  level_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_q <= S_LOW;
               cnt_q   <= '0;
               level_q <= 1'b0;
            end
         endcase
      end
   end

   // Flag/count next state: clears apply first, so a press on the same edge overrides them.
   always_comb begin
      pressed_d = pressed_q;
      count_d   = count_q;
      if (rd_acc || (wr_acc && data[0])) pressed_d = 1'b0;
      if (wr_acc && data[1])             count_d   = 8'd0;
      if (press_evt) begin
         pressed_d = 1'b1;
         count_d   = count_d + 8'd1;
      end
   end

   // Sticky flag and press counter registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pressed_q <= 1'b0;
         count_q   <= 8'd0;
      end else begin
         pressed_q <= pressed_d;
         count_q   <= count_d;
      end
   end

   // Read snapshot: captures the pre-update status word to line up with the RAM read latency.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hit_q  <= 1'b0;
         snap_q <= 32'd0;
      end else begin
         hit_q  <= rd_acc;
         snap_q <= status_d;
      end
   end

endmodule

// File: tb/tb_button_mmio.sv
// tb_button_mmio: random and directed stimulus for button_mmio, checked against
// a behavioural model built from run lengths of the synchronised button level.
module tb_button_mmio;

   localparam int          DC     = 4;
   localparam int          ADDR   = 24;
   localparam logic [11:0] ADDR12 = 12'(ADDR);

   logic        clock = 1'b0;
   logic        reset;
   logic        btn_raw;
   logic [31:0] address_dmem;
   logic        wren;
   logic [31:0] data;
   logic [31:0] ram_q;
   logic        ram_wren;
   logic [31:0] q_dmem;
   logic        btn_level;
   logic        btn_pressed;
   logic [7:0]  press_count;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   button_mmio #(.BTN_ADDR(ADDR), .DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
      .clock(clock), .reset(reset), .btn_raw(btn_raw), .address_dmem(address_dmem),
      .wren(wren), .data(data), .ram_q(ram_q), .ram_wren(ram_wren), .q_dmem(q_dmem),
      .btn_level(btn_level), .btn_pressed(btn_pressed), .press_count(press_count)
   );

   // Reference model state
   bit          m_s1, m_s2, m_level, m_pressed, m_hitq;
   int          m_run;
   logic [7:0]  m_count;
   logic [31:0] m_snap;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_level = 0; m_pressed = 0; m_hitq = 0;
      m_run = 0; m_count = 0; m_snap = 0;
   endtask

   // One clock edge of the peripheral. A new level is accepted once the
   // synchronised input has differed from it for DC consecutive edges.
   task automatic model_edge(input bit raw, input logic [31:0] a, input bit we, input logic [31:0] d);
      bit hit, rd, wr, press;
      hit = (a[11:0] == ADDR12);
      rd  = hit && !we;
      wr  = hit && we;
      m_snap = {16'b0, m_count, 6'b0, m_pressed, m_level};
      m_hitq = rd;
      press = 0;
      if (m_s2 != m_level) begin
         m_run++;
         if (m_run == DC) begin
            m_level = m_s2;
            m_run   = 0;
            press   = m_level;
         end
      end else begin
         m_run = 0;
      end
      if (press) m_count = (wr && d[1]) ? 8'd1 : m_count + 8'd1;
      else if (wr && d[1]) m_count = 8'd0;
      if (press) m_pressed = 1;
      else if (rd || (wr && d[0])) m_pressed = 0;
      m_s2 = m_s1;
      m_s1 = raw;
   endtask

   // Drive one cycle of inputs at the falling edge, then check after the rising edge.
   task automatic step(input bit raw, input logic [31:0] a, input bit we,
                       input logic [31:0] d, input logic [31:0] rq);
      @(negedge clock);
      reset = 1'b0;
      btn_raw = raw; address_dmem = a; wren = we; data = d; ram_q = rq;
      #1 check("ram_wren", {31'b0, ram_wren}, (a[11:0] == ADDR12) ? 32'd0 : {31'b0, we});
      @(posedge clock);
      model_edge(raw, a, we, d);
      #1;
      check("btn_level", {31'b0, btn_level}, {31'b0, m_level});
      check("btn_pressed", {31'b0, btn_pressed}, {31'b0, m_pressed});
      check("press_count", {24'b0, press_count}, {24'b0, m_count});
      check("q_dmem", q_dmem, m_hitq ? m_snap : rq);
   endtask

   task automatic idle(input bit raw, input int n);
      for (int i = 0; i < n; i++) step(raw, 32'd5, 1'b0, 32'd0, $urandom);
   endtask

   task automatic press_once();
      idle(1'b1, 6);
      idle(1'b0, 6);
   endtask

   // Asserts reset between edges and checks that everything clears immediately.
   task automatic async_reset(input string tag);
      #2;
      ram_q = 32'd0;
      reset = 1'b1;
      #1;
      model_reset();
      check({tag, "_level"}, {31'b0, btn_level}, 32'd0);
      check({tag, "_pressed"}, {31'b0, btn_pressed}, 32'd0);
      check({tag, "_count"}, {24'b0, press_count}, 32'd0);
      check({tag, "_q"}, q_dmem, 32'd0);
   endtask

   initial begin
      reset = 1'b1; btn_raw = 0; address_dmem = 0; wren = 0; data = 0; ram_q = 0;
      #22;
      model_reset();
      check("rst_level", {31'b0, btn_level}, 32'd0);
      check("rst_pressed", {31'b0, btn_pressed}, 32'd0);
      check("rst_count", {24'b0, press_count}, 32'd0);
      check("rst_q", q_dmem, 32'd0);

      // Reset state readback and pass-through of RAM data
      step(0, 32'd24, 0, 32'd0, 32'h12345678);
      check("t1_status0", q_dmem, 32'd0);
      step(0, 32'd5, 0, 32'd0, 32'hDEADBEEF);
      check("t1_ram", q_dmem, 32'hDEADBEEF);

      // Clean press and the debounce latency
      for (int i = 0; i < 8; i++) begin
         step(1, 32'd5, 0, 32'd0, $urandom);
         if (i == 4) check("t2_level_early", {31'b0, btn_level}, 32'd0);
         if (i == 5) check("t2_level_on", {31'b0, btn_level}, 32'd1);
      end
      step(1, 32'd24, 0, 32'd0, $urandom);
      check("t2_read1", q_dmem, 32'h103);
      step(1, 32'd24, 0, 32'd0, $urandom);
      check("t2_read2", q_dmem, 32'h101);
      idle(0, 8);

      // Bounce shorter than the debounce window
      step(0, 32'd24, 1, 32'h2, $urandom);
      for (int i = 0; i < 14; i++) begin
         step((i == 0 || i == 1 || i == 3 || i == 4), 32'd5, 0, 32'd0, $urandom);
         check("t3_no_level", {31'b0, btn_level}, 32'd0);
      end
      check("t3_count", {24'b0, press_count}, 32'd0);
      step(0, 32'd24, 0, 32'd0, $urandom);
      check("t3_status", q_dmem, 32'd0);

      // Store interception and write-clear
      for (int i = 0; i < 3; i++) press_once();
      check("t4_count3", {24'b0, press_count}, 32'd3);
      step(0, 32'd24, 1, 32'h2, $urandom);
      check("t4_clr_count", {24'b0, press_count}, 32'd0);
      check("t4_keep_flag", {31'b0, btn_pressed}, 32'd1);
      step(0, 32'd24, 1, 32'h1, $urandom);
      check("t4_clr_flag", {31'b0, btn_pressed}, 32'd0);
      step(0, 32'd25, 1, $urandom, $urandom);
      check("t4_ram_wren", {31'b0, ram_wren}, 32'd1);

      // Press on the same edge as a status read
      for (int i = 0; i < 5; i++) step(1, 32'd5, 0, 32'd0, $urandom);
      step(1, 32'd24, 0, 32'd0, $urandom);
      check("t5_snap_bit1", {31'b0, q_dmem[1]}, 32'd0);
      check("t5_flag_set", {31'b0, btn_pressed}, 32'd1);
      idle(0, 6);
      step(0, 32'd24, 1, 32'h3, $urandom);
      for (int i = 0; i < 256; i++) press_once();
      check("t5_wrap", {24'b0, press_count}, 32'd0);

      // Async reset while the FSM is mid-rise
      idle(0, 6);
      for (int i = 0; i < 4; i++) step(1, 32'd5, 0, 32'd0, 32'd0);
      async_reset("t6_rst");
      for (int i = 0; i < 7; i++) begin
         step(1, 32'd5, 0, 32'd0, $urandom);
         if (i == 4) check("t6_level_early", {31'b0, btn_level}, 32'd0);
         if (i == 5) check("t6_level_on", {31'b0, btn_level}, 32'd1);
      end
      check("t6_count", {24'b0, press_count}, 32'd1);

      // Randomised traffic with slowly changing, bouncy button input
      begin
         bit raw = 0;
         for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            if ($urandom_range(5) == 0) raw = ~raw;
            case ($urandom_range(3))
               0: a = 32'd24;
               1: a = 32'd24 + 32'h1000 * $urandom_range(7);
               2: a = 32'd25;
               default: a = $urandom;
            endcase
            step(raw, a, $urandom_range(3) == 0, $urandom, $urandom);
            if ($urandom_range(299) == 0) async_reset("rnd_rst");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
